sdram_port_arbiter: RTL and testbench

// Shares one toggle-handshake SDRAM controller channel between three toggle-handshake requesters:

---
 rtl/sdram_port_arbiter.sv | 151 +++++++++++++++
 tb/tb_sdram_port_arbiter.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/sdram_port_arbiter.sv
// Three-way toggle-handshake arbiter in front of a single SDRAM controller port.
// Fixed priority 0>1>2 with a starvation guard that forces a port-2 grant.
module sdram_port_arbiter #(
  parameter int unsigned AW           = 24,
  parameter int unsigned STARVE_LIMIT = 8
) (
  input  logic          clk_sys,
  input  logic          reset,
  input  logic [AW-1:0] addr0,
  input  logic          req0,
  output logic          ack0,
  input  logic          wr0,
  input  logic [1:0]    be0,
  input  logic [15:0]   din0,
  output logic [15:0]   dout0,
  input  logic [AW-1:0] addr1,
  input  logic          req1,
  output logic          ack1,
  input  logic          wr1,
  input  logic [1:0]    be1,
  input  logic [15:0]   din1,
  output logic [15:0]   dout1,
  input  logic [AW-1:0] addr2,
  input  logic          req2,
  output logic          ack2,
  input  logic          wr2,
  input  logic [1:0]    be2,
  input  logic [15:0]   din2,
  output logic [15:0]   dout2,
  output logic [AW-1:0] mem_addr,
  output logic          mem_req,
  input  logic          mem_ack,
  output logic          mem_we,
  output logic [1:0]    mem_be,
  output logic [15:0]   mem_din,
  input  logic [15:0]   mem_dout,
  output logic          busy
);

  localparam logic [7:0] StarveMax = 8'(STARVE_LIMIT);

  typedef enum logic [0:0] {StIdle, StWait} state_e;

  state_e        state;
  logic [1:0]    grant;
  logic [7:0]    starve_cnt;

  logic          pend0, pend1, pend2, any_pend;
  logic [1:0]    winner;
  logic [AW-1:0] win_addr;
  logic          win_wr;
  logic [1:0]    win_be;
  logic [15:0]   win_din;

  assign pend0    = req0 ^ ack0;
  assign pend1    = req1 ^ ack1;
  assign pend2    = req2 ^ ack2;
  assign any_pend = pend0 | pend1 | pend2;

  always_comb begin
    winner = 2'd0;
    if (pend2 && starve_cnt == StarveMax) winner = 2'd2;
    else if (pend0)                       winner = 2'd0;
    else if (pend1)                       winner = 2'd1;
    else if (pend2)                       winner = 2'd2;
  end

  always_comb begin
    win_addr = addr0;
    win_wr   = wr0;
    win_be   = be0;
    win_din  = din0;
    case (winner)
      2'd1: begin
        win_addr = addr1;
        win_wr   = wr1;
        win_be   = be1;
        win_din  = din1;
      end
      2'd2: begin
        win_addr = addr2;
        win_wr   = wr2;
        win_be   = be2;
        win_din  = din2;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state      <= StIdle;
      grant      <= 2'd0;
      starve_cnt <= 8'd0;
      ack0       <= 1'b0;
      ack1       <= 1'b0;
      ack2       <= 1'b0;
      dout0      <= 16'h0;
      dout1      <= 16'h0;
      dout2      <= 16'h0;
      mem_addr   <= '0;
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_be     <= 2'b00;
      mem_din    <= 16'h0;
      busy       <= 1'b0;
    end else begin
      // Port 2 not waiting means nothing is being starved.
      if (!pend2) starve_cnt <= 8'd0;
      unique case (state)
        StIdle: begin
          if (any_pend) begin
            mem_addr <= win_addr;
            mem_we   <= win_wr;
            mem_be   <= win_be;
            mem_din  <= win_din;
            mem_req  <= ~mem_req;
            grant    <= winner;
            busy     <= 1'b1;
            state    <= StWait;
            if (winner == 2'd2) starve_cnt <= 8'd0;
            else if (pend2 && starve_cnt != StarveMax) starve_cnt <= starve_cnt + 8'd1;
          end
        end
        StWait: begin
          if (mem_ack == mem_req) begin
            case (grant)
              2'd0: begin
                if (!mem_we) dout0 <= mem_dout;
                ack0 <= ~ack0;
              end
              2'd1: begin
                if (!mem_we) dout1 <= mem_dout;
                ack1 <= ~ack1;
              end
              2'd2: begin
                if (!mem_we) dout2 <= mem_dout;
                ack2 <= ~ack2;
              end
              default: ;
            endcase
            busy  <= 1'b0;
            state <= StIdle;
          end
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Directed bench for sdram_port_arbiter: single-access vector table plus
// hand-written priority, starvation, churn and reset sequences.
module tb_sdram_port_arbiter;
  localparam int AW = 24;

  logic                clk_sys = 1'b0;
  logic                reset;
  logic [2:0][AW-1:0]  addr;
  logic [2:0]          req, wr;
  logic [2:0][1:0]     be;
  logic [2:0][15:0]    din;
  logic                ack0, ack1, ack2;
  logic [15:0]         dout0, dout1, dout2;
  logic [AW-1:0]       mem_addr;
  logic                mem_req, mem_ack, mem_we, busy;
  logic [1:0]          mem_be;
  logic [15:0]         mem_din, mem_dout;
  wire  [2:0]          ack = {ack2, ack1, ack0};

  logic [15:0] rd_value;
  int          lat_cnt;
  int          n_tests = 0;
  int          n_fail  = 0;

  always #5 clk_sys = ~clk_sys;

  sdram_port_arbiter #(.AW(AW), .STARVE_LIMIT(8)) dut (
    .clk_sys(clk_sys), .reset(reset),
    .addr0(addr[0]), .req0(req[0]), .ack0(ack0), .wr0(wr[0]), .be0(be[0]), .din0(din[0]),
    .dout0(dout0),
    .addr1(addr[1]), .req1(req[1]), .ack1(ack1), .wr1(wr[1]), .be1(be[1]), .din1(din[1]),
    .dout1(dout1),
    .addr2(addr[2]), .req2(req[2]), .ack2(ack2), .wr2(wr[2]), .be2(be[2]), .din2(din[2]),
    .dout2(dout2),
    .mem_addr(mem_addr), .mem_req(mem_req), .mem_ack(mem_ack), .mem_we(mem_we),
    .mem_be(mem_be), .mem_din(mem_din), .mem_dout(mem_dout), .busy(busy)
  );

  // Controller model: answers 4 cycles after seeing a new request toggle.
  always @(posedge clk_sys) begin
    if (reset) begin
      mem_ack  <= 1'b0;
      mem_dout <= 16'h0;
      lat_cnt  <= 0;
    end else if (mem_req != mem_ack) begin
      if (lat_cnt == 3) begin
        mem_ack  <= mem_req;
        mem_dout <= rd_value;
        lat_cnt  <= 0;
      end else begin
        lat_cnt <= lat_cnt + 1;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic issue(input int p, input logic w, input logic [AW-1:0] a,
                       input logic [1:0] b, input logic [15:0] d);
    addr[p] = a;
    wr[p]   = w;
    be[p]   = b;
    din[p]  = d;
    req[p]  = ~req[p];
  endtask

  task automatic wait_done(input int p, output int cyc);
    cyc = 0;
    while (ack[p] != req[p] && cyc < 40) begin
      @(negedge clk_sys);
      cyc++;
    end
    chk($sformatf("ack%0d_done", p), {31'b0, ack[p]}, {31'b0, req[p]});
  endtask

  task automatic next_grant(output logic [AW-1:0] a, output logic [1:0] b,
                            output logic [15:0] d);
    logic last;
    int   cyc;
    last = mem_req;
    cyc  = 0;
    while (mem_req == last && cyc < 40) begin
      @(negedge clk_sys);
      cyc++;
    end
    chk("grant_seen", {31'b0, mem_req ^ last}, 32'd1);
    a = mem_addr;
    b = mem_be;
    d = mem_din;
    cyc = 0;
    while (busy && cyc < 40) begin
      @(negedge clk_sys);
      cyc++;
    end
    chk("grant_done", {31'b0, busy}, 32'd0);
  endtask

  typedef struct {
    int          port;
    logic        wr;
    logic [23:0] addr;
    logic [1:0]  be;
    logic [15:0] din;
    logic [15:0] rdata;
    logic [15:0] d0, d1, d2;
  } vec_t;

  vec_t vecs[6];

  initial begin
    logic [AW-1:0] ga;
    logic [1:0]    gb;
    logic [15:0]   gd;
    logic          exp_mreq;
    int            cyc;

    vecs[0] = '{0, 1'b0, 24'h000100, 2'b11, 16'h0000, 16'hBEEF, 16'hBEEF, 16'h0000, 16'h0000};
    vecs[1] = '{2, 1'b0, 24'h000200, 2'b11, 16'h0000, 16'hAAAA, 16'hBEEF, 16'h0000, 16'hAAAA};
    vecs[2] = '{1, 1'b1, 24'h000300, 2'b10, 16'h1234, 16'hDEAD, 16'hBEEF, 16'h0000, 16'hAAAA};
    vecs[3] = '{2, 1'b0, 24'h000204, 2'b11, 16'h0000, 16'h5555, 16'hBEEF, 16'h0000, 16'h5555};
    vecs[4] = '{0, 1'b1, 24'h000101, 2'b01, 16'h4321, 16'h9999, 16'hBEEF, 16'h0000, 16'h5555};
    vecs[5] = '{1, 1'b0, 24'h000003, 2'b11, 16'h0000, 16'h0F0F, 16'hBEEF, 16'h0F0F, 16'h5555};

    reset    = 1'b1;
    addr     = '0;
    req      = '0;
    wr       = '0;
    be       = '0;
    din      = '0;
    rd_value = 16'h0;
    exp_mreq = 1'b0;
    repeat (3) @(negedge clk_sys);
    reset = 1'b0;
    @(negedge clk_sys);

    chk("rst_ack",      {29'b0, ack},       32'd0);
    chk("rst_mem_req",  {31'b0, mem_req},   32'd0);
    chk("rst_busy",     {31'b0, busy},      32'd0);
    chk("rst_mem_addr", {8'b0, mem_addr},   32'd0);
    chk("rst_mem_we",   {31'b0, mem_we},    32'd0);
    chk("rst_dout0",    {16'b0, dout0},     32'd0);

    // Single accesses, one at a time.
    for (int i = 0; i < 6; i++) begin
      rd_value = vecs[i].rdata;
      issue(vecs[i].port, vecs[i].wr, vecs[i].addr, vecs[i].be, vecs[i].din);
      exp_mreq = ~exp_mreq;
      @(negedge clk_sys);
      chk($sformatf("v%0d_busy", i),     {31'b0, busy},     32'd1);
      chk($sformatf("v%0d_mem_req", i),  {31'b0, mem_req},  {31'b0, exp_mreq});
      chk($sformatf("v%0d_mem_addr", i), {8'b0, mem_addr},  {8'b0, vecs[i].addr});
      chk($sformatf("v%0d_mem_we", i),   {31'b0, mem_we},   {31'b0, vecs[i].wr});
      chk($sformatf("v%0d_mem_be", i),   {30'b0, mem_be},   {30'b0, vecs[i].be});
      chk($sformatf("v%0d_mem_din", i),  {16'b0, mem_din},  {16'b0, vecs[i].din});
      wait_done(vecs[i].port, cyc);
      chk($sformatf("v%0d_latency", i),  cyc,               32'd5);
      chk($sformatf("v%0d_busy_end", i), {31'b0, busy},     32'd0);
      chk($sformatf("v%0d_dout0", i),    {16'b0, dout0},    {16'b0, vecs[i].d0});
      chk($sformatf("v%0d_dout1", i),    {16'b0, dout1},    {16'b0, vecs[i].d1});
      chk($sformatf("v%0d_dout2", i),    {16'b0, dout2},    {16'b0, vecs[i].d2});
    end

    // Input churn during WAIT must not reach mem_*.
    issue(0, 1'b1, 24'h000400, 2'b11, 16'h1111);
    @(negedge clk_sys);
    for (int i = 0; i < 3; i++) begin
      addr[0] = 24'h0004F0 + 24'(i);
      din[0]  = 16'hC000 + 16'(i);
      @(negedge clk_sys);
      chk($sformatf("churn%0d_addr", i), {8'b0, mem_addr}, 32'h400);
      chk($sformatf("churn%0d_din", i),  {16'b0, mem_din}, 32'h1111);
    end
    wait_done(0, cyc);

    // Simultaneous requests: fixed priority 0, 1, 2.
    issue(0, 1'b0, 24'h000010, 2'b11, 16'h0000);
    issue(1, 1'b1, 24'h000011, 2'b10, 16'h5A5A);
    issue(2, 1'b0, 24'h000012, 2'b11, 16'h0000);
    next_grant(ga, gb, gd);
    chk("prio_g0_addr", {8'b0, ga}, 32'h10);
    next_grant(ga, gb, gd);
    chk("prio_g1_addr", {8'b0, ga}, 32'h11);
    chk("prio_g1_be",   {30'b0, gb}, 32'h2);
    chk("prio_g1_din",  {16'b0, gd}, 32'h5A5A);
    next_grant(ga, gb, gd);
    chk("prio_g2_addr", {8'b0, ga}, 32'h12);
    chk("prio_acks",    {29'b0, ack}, {29'b0, req});

    // Starvation: port 0 back-to-back, port 2 forced in as the 9th access.
    issue(0, 1'b0, 24'h000020, 2'b11, 16'h0000);
    issue(2, 1'b0, 24'h000022, 2'b11, 16'h0000);
    for (int k = 0; k < 10; k++) begin
      next_grant(ga, gb, gd);
      chk($sformatf("starve_g%0d", k), {8'b0, ga}, (k == 8) ? 32'h22 : 32'h20);
      if (k < 9 && ack[0] == req[0]) req[0] = ~req[0];
    end
    // Counter must have cleared: a fresh tie goes to port 0 first.
    issue(0, 1'b0, 24'h000020, 2'b11, 16'h0000);
    issue(2, 1'b0, 24'h000022, 2'b11, 16'h0000);
    next_grant(ga, gb, gd);
    chk("starve_clr_g0", {8'b0, ga}, 32'h20);
    next_grant(ga, gb, gd);
    chk("starve_clr_g1", {8'b0, ga}, 32'h22);

    // Reset while port 2 is outstanding; requesters realign to 0 as well.
    rd_value = 16'h6666;
    issue(2, 1'b0, 24'h000600, 2'b11, 16'h0000);
    @(negedge clk_sys);
    chk("rmid_busy_pre", {31'b0, busy}, 32'd1);
    reset = 1'b1;
    req   = '0;
    @(negedge clk_sys);
    reset = 1'b0;
    chk("rmid_ack",     {29'b0, ack},     32'd0);
    chk("rmid_mem_req", {31'b0, mem_req}, 32'd0);
    chk("rmid_busy",    {31'b0, busy},    32'd0);
    chk("rmid_dout2",   {16'b0, dout2},   32'd0);
    rd_value = 16'h7777;
    issue(0, 1'b0, 24'h000500, 2'b11, 16'h0000);
    @(negedge clk_sys);
    chk("rmid_new_addr", {8'b0, mem_addr}, 32'h500);
    wait_done(0, cyc);
    chk("rmid_new_dout0", {16'b0, dout0}, 32'h7777);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
